// File: rtl/fir_mac_arbiter.sv
// fir_mac_arbiter: round-robin arbiter that lends one shared multiply-accumulate
// datapath to NUM_REQ decimating FIR engines. The grant is locked for one TAPS-beat
// convolution, and the dequantised sum is then returned to the winning engine.
// Optional watchdog: define FIR_ARB_TIMEOUT_EN to abort stalled bursts after TIMEOUT
// beatless ACC cycles and raise the sticky err_timeout flag.
module fir_mac_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned TAPS       = 32,
  parameter int unsigned BITS       = 10,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req,
  output logic [NUM_REQ-1:0]                  gnt,
  input  logic [NUM_REQ-1:0]                  op_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  op_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  op_b,
  output logic [DATA_WIDTH-1:0]               res_out,
  output logic [NUM_REQ-1:0]                  res_valid,
  output logic                                busy,
  output logic                                err_timeout
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(TAPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [PW-1:0]           win_q, win_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [DATA_WIDTH-1:0]   res_q, res_d;
  logic [NUM_REQ-1:0]      rv_q, rv_d;

  logic                    beat;
  logic [DATA_WIDTH-1:0]   prod;
  logic [DATA_WIDTH-1:0]   term;
  logic [DATA_WIDTH-1:0]   acc_sum;
  logic                    wd_expired;
  logic [PW-1:0]           sel;
  logic                    sel_found;
  int unsigned             idx;

  // Shared MAC datapath: the low half of a product is the same for signed and
  // unsigned operands, so only the dequantising shift needs to be signed.
  always_comb begin
    beat    = op_valid[win_q];
    prod    = op_a[win_q] * op_b[win_q];
    term    = $signed(prod) >>> BITS;
    acc_sum = acc_q + term;
  end

  // Round-robin pick: first requester after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    sel       = ptr_q;
    sel_found = 1'b0;
    idx       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!sel_found && req[PW'(idx)]) begin
        sel       = PW'(idx);
        sel_found = 1'b1;
      end
    end
  end

`ifdef FIR_ARB_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d;

  // Watchdog: count beatless ACC cycles, restart on every granted beat.
  always_comb begin
    wd_expired = (state_q == S_ACC) && !beat && (wd_q == WW'(TIMEOUT - 1));
    wd_d       = ((state_q == S_ACC) && !beat) ? wd_q + 1'b1 : '0;
    err_d      = err_q | wd_expired;
  end

  // Watchdog registers; err is sticky until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  // State register and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(NUM_REQ - 1);
      win_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      res_q   <= '0;
      rv_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
    end
  end

  // Next-state logic. The result strobe is registered on the final beat so it
  // is visible during DONE; an abort outranks a beat arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    res_d   = res_q;
    rv_d    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          win_d   = sel;
          gnt_d   = NUM_REQ'(1) << sel;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (!req[win_q] || wd_expired) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          ptr_d   = win_q;
        end else if (beat) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(TAPS - 1)) begin
            state_d = S_DONE;
            gnt_d   = '0;
            res_d   = acc_sum;
            rv_d    = NUM_REQ'(1) << win_q;
          end
        end
      end
      S_DONE: begin
        ptr_d   = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    gnt       = gnt_q;
    res_out   = res_q;
    res_valid = rv_q;
    busy      = (state_q != S_IDLE);
`ifdef FIR_ARB_TIMEOUT_EN
    err_timeout = err_q;
`else
    err_timeout = 1'b0;
`endif
  end

endmodule

// File: tb/tb_fir_mac_arbiter.sv
// Directed self-checking bench for fir_mac_arbiter (TAPS=4, TIMEOUT=8).
module tb_fir_mac_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 2;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic [NR-1:0]          req = '0;
  logic [NR-1:0]          gnt;
  logic [NR-1:0]          op_valid = '0;
  logic [NR-1:0][DW-1:0]  op_a = '0;
  logic [NR-1:0][DW-1:0]  op_b = '0;
  logic [DW-1:0]          res_out;
  logic [NR-1:0]          res_valid;
  logic                   busy;
  logic                   err_timeout;

  int checks = 0;
  int errors = 0;

  fir_mac_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ(NR),
    .TAPS(4),
    .BITS(10),
    .TIMEOUT(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .gnt(gnt),
    .op_valid(op_valid),
    .op_a(op_a),
    .op_b(op_b),
    .res_out(res_out),
    .res_valid(res_valid),
    .busy(busy),
    .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1, "bench did not finish");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req = '0;
    op_valid = '0;
    do_reset();
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", gnt); end
    checks++;
    if (res_valid !== 2'b00) begin errors++; $display("FAIL reset_res_valid got %b want 00", res_valid); end
    checks++;
    if (res_out !== 32'd0) begin errors++; $display("FAIL reset_res_out got %h want 0", res_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_timeout); end
  endtask

  task automatic test_arith();
    req = 2'b01;
    tick();
    checks++;
    if (gnt !== 2'b01 || busy !== 1'b1) begin
      errors++; $display("FAIL arith_grant got gnt=%b busy=%b want 01/1", gnt, busy);
    end
    op_valid = 2'b01;
    op_a[0] = 32'd1024;
    op_b[0] = 32'd3;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (res_valid !== 2'b00 || gnt !== 2'b01) begin
        errors++; $display("FAIL arith_mid beat %0d got rv=%b gnt=%b want 00/01", k, res_valid, gnt);
      end
    end
    tick();
    checks++;
    if (res_valid !== 2'b01) begin errors++; $display("FAIL arith_rv got %b want 01", res_valid); end
    checks++;
    if (res_out !== 32'd12) begin errors++; $display("FAIL arith_res got %h want c", res_out); end
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL arith_done_gnt got %b want 00", gnt); end
    req = '0;
    op_valid = '0;
    tick();
    checks++;
    if (res_valid !== 2'b00 || busy !== 1'b0 || res_out !== 32'd12) begin
      errors++; $display("FAIL arith_after got rv=%b busy=%b res=%h want 00/0/c", res_valid, busy, res_out);
    end
  endtask

  task automatic test_negative();
    req = 2'b01;
    tick();
    op_valid = 2'b01;
    op_a[0] = 32'hffff_ffff;
    op_b[0] = 32'd1024;
    tick(); tick(); tick(); tick();
    checks++;
    if (res_valid !== 2'b01 || res_out !== 32'hffff_fffc) begin
      errors++; $display("FAIL negative_res got rv=%b res=%h want 01/fffffffc", res_valid, res_out);
    end
    req = '0;
    op_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_g;
    logic [DW-1:0] exp_r;
    req = 2'b11;
    op_valid = 2'b11;
    op_a[0] = 32'd1024; op_b[0] = 32'd1;
    op_a[1] = 32'd1024; op_b[1] = 32'd2;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_r = (k % 2 == 0) ? 32'd4 : 32'd8;
      tick();
      checks++;
      if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt burst %0d got %b want %b", k, gnt, exp_g); end
      tick(); tick(); tick(); tick();
      checks++;
      if (res_valid !== exp_g || res_out !== exp_r) begin
        errors++; $display("FAIL rr_res burst %0d got rv=%b res=%h want %b/%h", k, res_valid, res_out, exp_g, exp_r);
      end
      tick();
      checks++;
      if (gnt !== 2'b00 || busy !== 1'b0) begin
        errors++; $display("FAIL rr_bubble burst %0d got gnt=%b busy=%b want 00/0", k, gnt, busy);
      end
    end
    req = '0;
    op_valid = '0;
    tick();
  endtask

  task automatic test_abort();
    req = 2'b11;
    op_valid = 2'b01;
    op_a[0] = 32'd1024; op_b[0] = 32'd3;
    do_reset();
    tick();
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL abort_first_gnt got %b want 01", gnt); end
    tick(); tick();
    req = 2'b10;
    tick();
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b0 || res_valid !== 2'b00) begin
      errors++; $display("FAIL abort_drop got gnt=%b busy=%b rv=%b want 00/0/00", gnt, busy, res_valid);
    end
    op_valid = 2'b10;
    op_a[1] = 32'd1024; op_b[1] = 32'd5;
    tick();
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL abort_next_gnt got %b want 10", gnt); end
    tick(); tick(); tick(); tick();
    checks++;
    if (res_valid !== 2'b10 || res_out !== 32'd20) begin
      errors++; $display("FAIL abort_next_res got rv=%b res=%h want 10/14", res_valid, res_out);
    end
    req = '0;
    op_valid = '0;
    tick();
  endtask

  task automatic test_foreign();
    req = 2'b01;
    op_valid = '0;
    do_reset();
    tick();
    op_valid = 2'b10;
    op_a[1] = 32'd1024; op_b[1] = 32'd100;
    tick();
    op_valid = 2'b01;
    op_a[0] = 32'd1024; op_b[0] = 32'd3;
    tick(); tick(); tick();
    checks++;
    if (res_valid !== 2'b00 || gnt !== 2'b01) begin
      errors++; $display("FAIL foreign_count got rv=%b gnt=%b want 00/01", res_valid, gnt);
    end
    op_valid = 2'b11;
    tick();
    checks++;
    if (res_valid !== 2'b01 || res_out !== 32'd12) begin
      errors++; $display("FAIL foreign_res got rv=%b res=%h want 01/c", res_valid, res_out);
    end
    req = '0;
    op_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    req = 2'b01;
    op_valid = 2'b01;
    op_a[0] = 32'd1024; op_b[0] = 32'd3;
    tick(); tick(); tick();
    reset = 1'b1;
    op_valid = '0;
    tick();
    checks++;
    if (gnt !== 2'b00 || res_valid !== 2'b00 || busy !== 1'b0 || res_out !== 32'd0 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_mid got gnt=%b rv=%b busy=%b res=%h err=%b want all 0",
                         gnt, res_valid, busy, res_out, err_timeout);
    end
    reset = 1'b0;
    req = '0;
    tick();
  endtask

`ifdef FIR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    req = 2'b01;
    op_valid = '0;
    do_reset();
    tick();
    for (int k = 0; k < 7; k++) tick();
    checks++;
    if (gnt !== 2'b01 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_early got gnt=%b err=%b want 01/0", gnt, err_timeout);
    end
    tick();
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b0 || err_timeout !== 1'b1 || res_valid !== 2'b00) begin
      errors++; $display("FAIL timeout_abort got gnt=%b busy=%b err=%b rv=%b want 00/0/1/00",
                         gnt, busy, err_timeout, res_valid);
    end
    req = '0;
    tick(); tick();
    checks++;
    if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", err_timeout); end
    do_reset();
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", err_timeout); end
  endtask
`else
  task automatic test_timeout();
    req = 2'b01;
    op_valid = '0;
    do_reset();
    tick();
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (gnt !== 2'b01 || busy !== 1'b1 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL no_watchdog got gnt=%b busy=%b err=%b want 01/1/0", gnt, busy, err_timeout);
    end
    req = '0;
    tick();
    checks++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL no_watchdog_drop got gnt=%b busy=%b want 00/0", gnt, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_arith();
    test_negative();
    test_round_robin();
    test_abort();
    test_foreign();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
